// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        IDLE,
        REQ
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Memory-side and decoder-side buses of the fetch stage.
interface fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_data;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ack;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_data,
        output instr_valid, instr, instr_pc,
        input  instr_ack
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_data,
        input  instr_valid, instr, instr_pc,
        output instr_ack
    );

endinterface

// File: rtl/sync_fifo.sv
// Prefetch queue: power-of-two ring buffer with flush.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr;
    logic [PW-1:0]    rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= data;
                wr      <= wr + 1'b1;
            end
            if (pop) begin
                rd <= rd + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, memory request FSM and prefetch queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_if.master           bus,
    output logic [CW-1:0]     count
);

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic [ADDR_W-1:0]         pc;
    logic                      push;
    logic                      pop;
    logic [CW-1:0]             count_next;
    logic                      issue_ok;
    logic [INSTR_W+ADDR_W-1:0] head;

    always_comb begin
        push       = (state == REQ) && bus.mem_ack && !redirect;
        pop        = bus.instr_ack && (count != '0) && !redirect;
        count_next = count + CW'(push) - CW'(pop);
        issue_ok   = en && !redirect && (count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect aborts any open request; otherwise REQ only ends on ack.
    always_comb begin
        state_next = state;
        unique case (1'b1)
            redirect:                     state_next = IDLE;
            (state == IDLE) && issue_ok:  state_next = REQ;
            push && !issue_ok:            state_next = IDLE;
            default:                      state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + 1'b1;
        end
    end

    always_comb begin
        bus.mem_req     = (state == REQ);
        bus.mem_addr    = pc;
        bus.instr_valid = (count != '0);
        {bus.instr, bus.instr_pc} = head;
    end

    sync_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .data  ({bus.mem_data, pc}),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] f(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    assign bus.mem_data = f(bus.mem_addr);

    // Reference: queue of fetched {instr, pc}, next PC, request-open flag
    logic [23:0] mq[$];
    logic        m_req = 1'b0;
    logic [7:0]  m_pc  = 8'h00;

    always @(posedge clk) begin
        bit psh;
        bit pp;
        if (!rst_n) begin
            mq.delete();
            m_req = 1'b0;
            m_pc  = 8'h00;
        end else if (redirect) begin
            mq.delete();
            m_req = 1'b0;
            m_pc  = redirect_pc;
        end else begin
            psh = m_req && bus.mem_ack;
            pp  = bus.instr_ack && (mq.size() > 0);
            if (pp) void'(mq.pop_front());
            if (psh) begin
                mq.push_back({f(m_pc), m_pc});
                m_pc++;
            end
            if (!m_req || psh) m_req = en && (mq.size() < DEPTH);
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
        bus.mem_ack = 1'b1; bus.instr_ack = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", bus.mem_req); end
        total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%0h want=0", bus.mem_addr); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", bus.instr_valid); end
        total++; if (bus.instr !== 16'h0) begin bad++; $display("FAIL rst_instr got=%0h want=0", bus.instr); end
        total++; if (bus.instr_pc !== 8'h00) begin bad++; $display("FAIL rst_ipc got=%0h want=0", bus.instr_pc); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL stream_req i=%0d got=%0h want=1", i, bus.mem_req); end
            total++; if (bus.mem_addr !== 8'(i)) begin bad++; $display("FAIL stream_addr got=%0h want=%0h", bus.mem_addr, i); end
            if (i > 0) begin
                total++; if (bus.instr_pc !== 8'(i - 1)) begin bad++; $display("FAIL stream_ipc got=%0h want=%0h", bus.instr_pc, i - 1); end
                total++; if (bus.instr !== f(8'(i - 1))) begin bad++; $display("FAIL stream_instr got=%0h want=%0h", bus.instr, f(8'(i - 1))); end
                total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count got=%0d want=1", count); end
            end
        end
    endtask

    task automatic test_fill();
        en = 1'b1; bus.mem_ack = 1'b1; bus.instr_ack = 1'b0;
        do_reset();
        repeat (8) @(negedge clk);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", count); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_req got=%0h want=0", bus.mem_req); end
        total++; if (bus.mem_addr !== 8'h04) begin bad++; $display("FAIL fill_addr got=%0h want=4", bus.mem_addr); end
        total++; if (bus.instr_pc !== 8'h00) begin bad++; $display("FAIL fill_ipc got=%0h want=0", bus.instr_pc); end
        bus.instr_ack = 1'b1;
        @(negedge clk);
        bus.instr_ack = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL pop_count got=%0d want=3", count); end
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL pop_req got=%0h want=1", bus.mem_req); end
        total++; if (bus.instr_pc !== 8'h01) begin bad++; $display("FAIL pop_ipc got=%0h want=1", bus.instr_pc); end
        @(negedge clk);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL refill_count got=%0d want=4", count); end
        total++; if (bus.mem_addr !== 8'h05) begin bad++; $display("FAIL refill_addr got=%0h want=5", bus.mem_addr); end
        repeat (3) @(negedge clk);
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL refill_req got=%0h want=0", bus.mem_req); end
    endtask

    task automatic test_held();
        en = 1'b1; bus.mem_ack = 1'b0; bus.instr_ack = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 8'h10;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL hold_req got=%0h want=1", bus.mem_req); end
            total++; if (bus.mem_addr !== 8'h10) begin bad++; $display("FAIL hold_addr got=%0h want=10", bus.mem_addr); end
        end
        bus.mem_ack = 1'b1; bus.instr_ack = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL held_idle got=%0h want=0", bus.mem_req); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL held_count got=%0d want=1", count); end
        total++; if (bus.instr_pc !== 8'h10) begin bad++; $display("FAIL held_ipc got=%0h want=10", bus.instr_pc); end
        total++; if (bus.instr !== f(8'h10)) begin bad++; $display("FAIL held_instr got=%0h want=%0h", bus.instr, f(8'h10)); end
        total++; if (bus.mem_addr !== 8'h11) begin bad++; $display("FAIL held_addr got=%0h want=11", bus.mem_addr); end
    endtask

    task automatic test_redirect();
        int n = 0;
        en = 1'b1; bus.mem_ack = 1'b1; bus.instr_ack = 1'b0;
        do_reset();
        while (count !== 3'd3 && n < 12) begin
            @(negedge clk);
            n++;
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL redir_fill got=%0d want=3", count); end
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL redir_open got=%0h want=1", bus.mem_req); end
        redirect = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d want=0", count); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%0h want=0", bus.mem_req); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%0h want=0", bus.instr_valid); end
        @(negedge clk);
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL redir_req2 got=%0h want=1", bus.mem_req); end
        total++; if (bus.mem_addr !== 8'h40) begin bad++; $display("FAIL redir_addr got=%0h want=40", bus.mem_addr); end
        @(negedge clk);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL redir_count2 got=%0d want=1", count); end
        total++; if (bus.instr_pc !== 8'h40) begin bad++; $display("FAIL redir_ipc got=%0h want=40", bus.instr_pc); end
    endtask

    task automatic test_wrap();
        en = 1'b1; bus.mem_ack = 1'b1; bus.instr_ack = 1'b1;
        redirect = 1'b1; redirect_pc = 8'hFE;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_addr !== 8'hFE) begin bad++; $display("FAIL wrap_fe got=%0h want=fe", bus.mem_addr); end
        @(negedge clk);
        total++; if (bus.mem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_ff got=%0h want=ff", bus.mem_addr); end
        @(negedge clk);
        total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL wrap_00 got=%0h want=0", bus.mem_addr); end
        total++; if (bus.instr_pc !== 8'hFF) begin bad++; $display("FAIL wrap_ipc got=%0h want=ff", bus.instr_pc); end
        @(negedge clk);
        total++; if (bus.instr_pc !== 8'h00) begin bad++; $display("FAIL wrap_ipc0 got=%0h want=0", bus.instr_pc); end
    endtask

    task automatic test_reset_mid_req();
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0h want=1", bus.mem_req); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%0h want=0", bus.mem_req); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
        total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL mid_addr got=%0h want=0", bus.mem_addr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            en            = ($urandom_range(0, 3) != 0);
            bus.mem_ack   = $urandom_range(0, 1) == 1;
            bus.instr_ack = $urandom_range(0, 1) == 1;
            redirect      = ($urandom_range(0, 15) == 0);
            redirect_pc   = 8'($urandom);
            @(negedge clk);
            total++; if (bus.mem_req !== m_req) begin bad++; $display("FAIL rnd_req i=%0d got=%0h want=%0h", i, bus.mem_req, m_req); end
            total++; if (bus.mem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr i=%0d got=%0h want=%0h", i, bus.mem_addr, m_pc); end
            total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count i=%0d got=%0d want=%0d", i, count, mq.size()); end
            total++; if (bus.instr_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid i=%0d got=%0h want=%0h", i, bus.instr_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                total++; if ({bus.instr, bus.instr_pc} !== mq[0]) begin bad++; $display("FAIL rnd_head i=%0d got=%0h want=%0h", i, {bus.instr, bus.instr_pc}, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_held();
        test_redirect();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
